// File: rtl/sprite_pkg.sv
// Shared timing constants and types for the sprite fetch scheduler.
package sprite_pkg;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_TOTAL   = 800;
    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_TOTAL   = 525;

    typedef enum logic [1:0] {StIdle, StScan, StFetch, StFinish} sched_state_t;

    typedef logic [3:0] pix_idx_t;

endpackage

// File: rtl/sprite_priority_mux.sv
// Combinational per-pixel sprite selection: lowest-indexed opaque sprite
// covering the current pixel wins.
module sprite_priority_mux
    import sprite_pkg::*;
#(
    parameter int unsigned NUM_SPRITES = 4,
    parameter int unsigned SPRITE_W    = 16
) (
    input  logic [9:0]                               draw_x_i,
    input  logic [9:0]                               draw_y_i,
    input  logic [NUM_SPRITES-1:0]                   line_valid_i,
    input  logic [NUM_SPRITES-1:0][9:0]              sprite_x_i,
    input  logic [NUM_SPRITES-1:0][SPRITE_W-1:0][3:0] line_buf_i,
    output logic [3:0]                               pix_index_o,
    output logic                                     pix_hit_o
);

    localparam int unsigned ColW = $clog2(SPRITE_W);

    logic        in_active;
    logic [10:0] col;
    pix_idx_t    pix;

    assign in_active = (draw_y_i < 10'(V_VISIBLE)) && (draw_x_i < 10'(H_VISIBLE));

    always_comb begin
        pix_index_o = '0;
        pix_hit_o   = 1'b0;
        col         = '0;
        pix         = '0;
        // Walk from lowest priority upward so the lowest index overwrites.
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            col = {1'b0, draw_x_i} - {1'b0, sprite_x_i[i]};
            pix = line_buf_i[i][col[ColW-1:0]];
            if (in_active && line_valid_i[i] && (col < 11'(SPRITE_W)) && (pix != '0)) begin
                pix_index_o = pix;
                pix_hit_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_fetch_sched.sv
// Sprite ROM fetch scheduler: fills per-sprite line buffers during hblank and
// emits the registered, priority-resolved sprite pixel during active video.
module sprite_fetch_sched
    import sprite_pkg::*;
#(
    parameter int unsigned NUM_SPRITES = 4,
    parameter int unsigned SPRITE_W    = 16,
    parameter int unsigned SPRITE_H    = 16,
    parameter int unsigned FRAME_W     = 4,
    parameter int unsigned ROM_AW      = 15
) (
    input  logic                              vga_clk,
    input  logic                              reset,
    input  logic [9:0]                        DrawX,
    input  logic [9:0]                        DrawY,
    input  logic [NUM_SPRITES-1:0]            sprite_en,
    input  logic [NUM_SPRITES-1:0][9:0]       sprite_x,
    input  logic [NUM_SPRITES-1:0][9:0]       sprite_y,
    input  logic [NUM_SPRITES-1:0][FRAME_W-1:0] sprite_frame,
    output logic [ROM_AW-1:0]                 rom_addr,
    input  logic [3:0]                        rom_q,
    output logic [3:0]                        pix_index,
    output logic                              pix_hit,
    output logic                              fetch_busy,
    output logic                              overrun
);

    localparam int unsigned IdxW = $clog2(NUM_SPRITES);
    localparam int unsigned ColW = $clog2(SPRITE_W);
    localparam int unsigned RowW = $clog2(SPRITE_H);

    sched_state_t             state_q, state_d;
    logic [IdxW-1:0]          idx_q, idx_d;
    logic [ColW-1:0]          col_q, col_d;
    logic [RowW-1:0]          row_q, row_d;
    logic [NUM_SPRITES-1:0]   line_valid_q, line_valid_d;
    logic                     overrun_q, overrun_d;
    logic                     cap_valid_q, cap_valid_d;
    logic [IdxW-1:0]          cap_idx_q;
    logic [ColW-1:0]          cap_col_q;
    pix_idx_t                 pix_index_q;
    logic                     pix_hit_q;
    logic [NUM_SPRITES-1:0][SPRITE_W-1:0][3:0] line_buf_q;

    logic [9:0]  next_y;
    logic [10:0] row_full;
    logic        row_visible;
    logic        last_idx;
    logic        abort;
    pix_idx_t    mux_index;
    logic        mux_hit;

    assign next_y      = (DrawY == 10'(V_TOTAL - 1)) ? '0 : DrawY + 10'd1;
    assign row_full    = {1'b0, next_y} - {1'b0, sprite_y[idx_q]};
    assign row_visible = sprite_en[idx_q] && (row_full < 11'(SPRITE_H));
    assign last_idx    = (idx_q == IdxW'(NUM_SPRITES - 1));
    // A fetch still running when the next line starts is abandoned.
    assign abort       = (state_q != StIdle) && (DrawX == '0);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        col_d        = col_q;
        row_d        = row_q;
        line_valid_d = line_valid_q;
        overrun_d    = 1'b0;
        cap_valid_d  = 1'b0;
        rom_addr     = '0;
        if (abort) begin
            state_d   = StIdle;
            overrun_d = 1'b1;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (IdxW'(i) >= idx_q) line_valid_d[i] = 1'b0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (DrawX == 10'(H_VISIBLE)) begin
                        if (next_y < 10'(V_VISIBLE)) begin
                            state_d = StScan;
                            idx_d   = '0;
                        end else begin
                            line_valid_d = '0;
                        end
                    end
                end
                StScan: begin
                    line_valid_d[idx_q] = row_visible;
                    if (row_visible) begin
                        col_d   = '0;
                        row_d   = row_full[RowW-1:0];
                        state_d = StFetch;
                    end else if (last_idx) begin
                        state_d = StFinish;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
                StFetch: begin
                    rom_addr    = ROM_AW'(32'(sprite_frame[idx_q]) * (SPRITE_W * SPRITE_H)
                                          + 32'(row_q) * SPRITE_W + 32'(col_q));
                    cap_valid_d = 1'b1;
                    col_d       = col_q + ColW'(1);
                    if (col_q == ColW'(SPRITE_W - 1)) begin
                        if (last_idx) begin
                            state_d = StFinish;
                        end else begin
                            idx_d   = idx_q + IdxW'(1);
                            state_d = StScan;
                        end
                    end
                end
                StFinish: state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            col_q        <= '0;
            row_q        <= '0;
            line_valid_q <= '0;
            overrun_q    <= 1'b0;
            cap_valid_q  <= 1'b0;
            pix_index_q  <= '0;
            pix_hit_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            col_q        <= col_d;
            row_q        <= row_d;
            line_valid_q <= line_valid_d;
            overrun_q    <= overrun_d;
            cap_valid_q  <= cap_valid_d;
            pix_index_q  <= mux_index;
            pix_hit_q    <= mux_hit;
        end
    end

    // ROM data lands one cycle after its address; the tag tracks where it goes.
    always_ff @(posedge vga_clk) begin
        cap_idx_q <= idx_q;
        cap_col_q <= col_q;
        if (!reset && cap_valid_q && !abort) begin
            line_buf_q[cap_idx_q][cap_col_q] <= rom_q;
        end
    end

    sprite_priority_mux #(
        .NUM_SPRITES (NUM_SPRITES),
        .SPRITE_W    (SPRITE_W)
    ) u_mux (
        .draw_x_i     (DrawX),
        .draw_y_i     (DrawY),
        .line_valid_i (line_valid_q),
        .sprite_x_i   (sprite_x),
        .line_buf_i   (line_buf_q),
        .pix_index_o  (mux_index),
        .pix_hit_o    (mux_hit)
    );

    assign pix_index  = pix_index_q;
    assign pix_hit    = pix_hit_q;
    assign fetch_busy = (state_q != StIdle);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_sprite_fetch_sched.sv
// Directed bench for sprite_fetch_sched with a behavioural sprite ROM and a
// scoreboard of expected pixel outputs.
module tb_sprite_fetch_sched;

    localparam int unsigned NS = 4;

    logic                 vga_clk = 1'b0;
    logic                 reset;
    logic [9:0]           DrawX, DrawY;
    logic [NS-1:0]        sprite_en;
    logic [NS-1:0][9:0]   sprite_x, sprite_y;
    logic [NS-1:0][3:0]   sprite_frame;
    logic [14:0]          rom_addr;
    logic [3:0]           rom_q;
    logic [3:0]           pix_index;
    logic                 pix_hit, fetch_busy, overrun;

    int checks = 0;
    int errors = 0;
    int rom_mode = 0;

    typedef struct {
        string      tag;
        logic [3:0] idx;
        logic       hit;
    } exp_t;
    exp_t sb[$];

    always #5 vga_clk = ~vga_clk;

    sprite_fetch_sched dut (
        .vga_clk      (vga_clk),
        .reset        (reset),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .sprite_en    (sprite_en),
        .sprite_x     (sprite_x),
        .sprite_y     (sprite_y),
        .sprite_frame (sprite_frame),
        .rom_addr     (rom_addr),
        .rom_q        (rom_q),
        .pix_index    (pix_index),
        .pix_hit      (pix_hit),
        .fetch_busy   (fetch_busy),
        .overrun      (overrun)
    );

    // Mode 0: word = addr[3:0]; mode 1: frame0 opaque only at col 5 (=7), others 3;
    // mode 2: word = row ^ 0xA.
    function automatic logic [3:0] rom_word(input logic [14:0] a);
        case (rom_mode)
            0:       return a[3:0];
            1:       return (a[14:8] == 7'd0) ? ((a[3:0] == 4'd5) ? 4'd7 : 4'd0) : 4'd3;
            default: return a[7:4] ^ 4'hA;
        endcase
    endfunction

    always @(posedge vga_clk) rom_q <= rom_word(rom_addr);

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic pix_step(input int x, input int y, input logic [3:0] ei, input logic eh,
                            input string tag);
        exp_t e;
        DrawX = 10'(x);
        DrawY = 10'(y);
        e.tag = tag;
        e.idx = ei;
        e.hit = eh;
        sb.push_back(e);
        tick();
        e = sb.pop_front();
        check({e.tag, "_idx"}, 32'(pix_index), 32'(e.idx));
        check({e.tag, "_hit"}, 32'(pix_hit), 32'(e.hit));
    endtask

    // Drives one horizontal blank from DrawX=640 to 799 and counts busy cycles.
    task automatic run_hblank(input int y, input int exp_busy, input int exp_addr0,
                              input string tag);
        int busy = 0;
        DrawY = 10'(y);
        DrawX = 10'd640;
        for (int k = 0; k < 159; k++) begin
            tick();
            if (k == 1 && exp_addr0 >= 0) check({tag, "_addr0"}, 32'(rom_addr), 32'(exp_addr0));
            if (fetch_busy) busy++;
            DrawX = 10'(641 + k);
        end
        check({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    endtask

    initial begin
        reset        = 1'b1;
        DrawX        = '0;
        DrawY        = '0;
        sprite_en    = '0;
        sprite_x     = '0;
        sprite_y     = '0;
        sprite_frame = '0;
        repeat (3) tick();
        check("rst_busy", 32'(fetch_busy), 32'd0);
        check("rst_addr", 32'(rom_addr), 32'd0);
        check("rst_idx", 32'(pix_index), 32'd0);
        check("rst_hit", 32'(pix_hit), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        reset = 1'b0;
        tick();

        // Basic fetch: one visible sprite.
        rom_mode        = 0;
        sprite_en       = 4'b0001;
        sprite_x[0]     = 10'd100;
        sprite_y[0]     = 10'd50;
        sprite_frame[0] = 4'd0;
        run_hblank(49, 21, 0, "basic");
        pix_step(100, 50, 4'd0, 1'b0, "basic_x100");
        pix_step(101, 50, 4'd1, 1'b1, "basic_x101");
        pix_step(115, 50, 4'hF, 1'b1, "basic_x115");
        pix_step(116, 50, 4'd0, 1'b0, "basic_x116");
        pix_step(99, 50, 4'd0, 1'b0, "basic_x99");

        // Priority and transparency: sprite 0 mostly clear over an all-3 sprite 1.
        rom_mode        = 1;
        sprite_en       = 4'b0011;
        sprite_x[0]     = 10'd200;
        sprite_x[1]     = 10'd200;
        sprite_y[0]     = 10'd100;
        sprite_y[1]     = 10'd100;
        sprite_frame[0] = 4'd0;
        sprite_frame[1] = 4'd1;
        run_hblank(99, 37, 0, "prio");
        for (int x = 200; x < 216; x++) begin
            pix_step(x, 100, (x == 205) ? 4'd7 : 4'd3, 1'b1, "prio_px");
        end
        pix_step(216, 100, 4'd0, 1'b0, "prio_right");

        // Vertical bounds near the bottom of the visible area.
        rom_mode        = 2;
        sprite_en       = 4'b0001;
        sprite_x[0]     = 10'd300;
        sprite_y[0]     = 10'd470;
        sprite_frame[0] = 4'd2;
        run_hblank(469, 21, 512, "vtop");
        pix_step(300, 470, 4'hA, 1'b1, "vtop_row0");
        pix_step(305, 470, 4'hA, 1'b1, "vtop_row0b");
        run_hblank(478, 21, 656, "vbot");
        pix_step(300, 479, 4'h3, 1'b1, "vbot_row9");
        run_hblank(479, 0, -1, "vend");
        pix_step(300, 480, 4'd0, 1'b0, "vend_blank");

        // Frame wrap: the blank after line 524 prepares line 0.
        sprite_x[0]     = 10'd10;
        sprite_y[0]     = 10'd0;
        sprite_frame[0] = 4'd0;
        run_hblank(524, 21, 0, "wrap");
        pix_step(10, 0, 4'hA, 1'b1, "wrap_row0");
        pix_step(9, 0, 4'd0, 1'b0, "wrap_left");

        // Overrun: line start arrives while sprite 1 is mid-fetch.
        rom_mode     = 0;
        sprite_en    = 4'b1111;
        sprite_x     = {10'd160, 10'd140, 10'd120, 10'd100};
        sprite_y     = {10'd200, 10'd200, 10'd200, 10'd200};
        sprite_frame = '0;
        DrawY        = 10'd199;
        DrawX        = 10'd640;
        for (int k = 0; k < 30; k++) begin
            tick();
            DrawX = 10'(641 + k);
        end
        check("ovr_busy_pre", 32'(fetch_busy), 32'd1);
        DrawX = 10'd0;
        DrawY = 10'd200;
        tick();
        check("ovr_pulse", 32'(overrun), 32'd1);
        check("ovr_idle", 32'(fetch_busy), 32'd0);
        pix_step(101, 200, 4'd1, 1'b1, "ovr_s0");
        check("ovr_pulse_end", 32'(overrun), 32'd0);
        pix_step(115, 200, 4'hF, 1'b1, "ovr_s0_last");
        pix_step(121, 200, 4'd0, 1'b0, "ovr_s1");
        pix_step(141, 200, 4'd0, 1'b0, "ovr_s2");
        pix_step(161, 200, 4'd0, 1'b0, "ovr_s3");

        // Reset in the middle of a fetch.
        DrawY = 10'd199;
        DrawX = 10'd640;
        for (int k = 0; k < 10; k++) begin
            tick();
            DrawX = 10'(700 + k);
        end
        check("rmid_busy_pre", 32'(fetch_busy), 32'd1);
        check("rmid_addr_pre", 32'(rom_addr), 32'd8);
        reset = 1'b1;
        tick();
        check("rmid_busy", 32'(fetch_busy), 32'd0);
        check("rmid_hit", 32'(pix_hit), 32'd0);
        check("rmid_addr", 32'(rom_addr), 32'd0);
        check("rmid_ovr", 32'(overrun), 32'd0);
        reset = 1'b0;
        pix_step(101, 200, 4'd0, 1'b0, "rmid_s0");
        pix_step(121, 200, 4'd0, 1'b0, "rmid_s1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
